// File: rtl/pipe_adder_pkg.sv
// Shared helpers for pipe_adder: slice-width calculation and configuration legality.
package pipe_adder_pkg;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // WIDTH must split into STAGES equal, non-empty slices
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_fa_slice.sv
// W-bit ripple-carry slice built from single-bit full-adder equations.
module fa_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one SW-bit slice per stage, valid/ready on both sides.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef PIPE_ADDER_OVF_EN
    output logic             co,
    output logic             ovf
`else
    output logic             co
`endif
);
    localparam int SW     = slice_w(WIDTH, STAGES);
    localparam int L      = STAGES - 1;
    localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);

    if (!CFG_OK) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // sum shifts right one slice per stage, so slice k lands at bits [k*SW +: SW] at the end;
    // operands shift right too, so every stage reads its slice from bits [SW-1:0]
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
    } stage_t;

    stage_t r_stage [STAGES];
    stage_t w_src   [STAGES];
    stage_t w_nxt   [STAGES];

    logic [STAGES-1:0][SW-1:0] w_sl_s;
    logic [STAGES-1:0]         w_sl_co;
    logic                      w_adv;

    assign w_adv    = out_ready | ~r_stage[L].valid;
    assign in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_src[k] = '{valid: in_valid, carry: ci, sum: '0, a_hi: a, b_hi: b};
        end else begin : g_body
            assign w_src[k] = r_stage[k - 1];
        end

        fa_slice #(.W(SW)) u_fa (
            .a  (w_src[k].a_hi[SW-1:0]),
            .b  (w_src[k].b_hi[SW-1:0]),
            .ci (w_src[k].carry),
            .s  (w_sl_s[k]),
            .co (w_sl_co[k])
        );

        assign w_nxt[k] = '{
            valid: w_src[k].valid,
            carry: w_sl_co[k],
            sum:   (w_src[k].sum >> SW) | (WIDTH'(w_sl_s[k]) << (WIDTH - SW)),
            a_hi:  w_src[k].a_hi >> SW,
            b_hi:  w_src[k].b_hi >> SW
        };
    end

    // full stall on backpressure: every stage holds together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= w_nxt[k];
        end
    end

    assign out_valid = r_stage[L].valid;
    assign s         = r_stage[L].sum;
    assign co        = r_stage[L].carry;

`ifdef PIPE_ADDER_OVF_EN
    logic w_msb_ci;
    logic r_ovf;

    // carry into the MSB recovered from its sum bit: s = a ^ b ^ cin
    assign w_msb_ci = w_src[L].a_hi[SW-1] ^ w_src[L].b_hi[SW-1] ^ w_sl_s[L][SW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_msb_ci ^ w_sl_co[L];
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed steps, expected sums queued at input transfer.
module tb_pipe_adder #(
    parameter int ST = 2
);
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef PIPE_ADDER_OVF_EN
        .co        (co),
        .ovf       (ovf)
`else
        .co        (co)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] sum;
        logic       ov;
        int         t;
    } exp_t;

    exp_t sb[$];
    bit   hist[int];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   lat_chk = 1'b1;
    bit   bub_chk = 1'b0;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
        exp_t e;
        int   sv;
        e.sum = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
        sv    = int'($signed(av)) + int'($signed(bv)) + int'(civ);
        e.ov  = (sv > 127) || (sv < -128);
        e.t   = 0;
        return e;
    endfunction

    // one cycle: drive, settle, pop/compare any output transfer, push any input transfer
    task automatic step(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic civ, input logic ordy);
        exp_t e;
        bit   xv;
        in_valid = iv; a = av; b = bv; ci = civ; out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out cyc=%0d got s=%h co=%b, required no output", cyc, s, co);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert ({co, s} === e.sum) else begin
                    errors++;
                    $error("FAIL sum cyc=%0d got %h, required %h", cyc, {co, s}, e.sum);
                end
`ifdef PIPE_ADDER_OVF_EN
                checks++;
                assert (ovf === e.ov) else begin
                    errors++;
                    $error("FAIL ovf cyc=%0d got %b, required %b", cyc, ovf, e.ov);
                end
`endif
                if (lat_chk) begin
                    checks++;
                    assert (cyc - e.t === ST) else begin
                        errors++;
                        $error("FAIL latency cyc=%0d got %0d, required %0d", cyc, cyc - e.t, ST);
                    end
                end
            end
        end
        if (bub_chk) begin
            xv = hist.exists(cyc - ST) ? hist[cyc - ST] : 1'b0;
            checks++;
            assert (out_valid === xv) else begin
                errors++;
                $error("FAIL bubble cyc=%0d got out_valid=%b, required %b", cyc, out_valid, xv);
            end
        end
        hist[cyc] = iv && in_ready;
        if (iv && in_ready) begin
            e   = model(av, bv, civ);
            e.t = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * ST + 8 && sb.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout got %0d pending, required 0", sb.size());
        end
    endtask

    logic [W-1:0] held_s;
    logic         held_co;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        assert (out_valid === 1'b0 && s === '0 && co === 1'b0 && in_ready === 1'b1) else begin
            errors++;
            $error("FAIL reset_state got v=%b s=%h co=%b rdy=%b, required 0/00/0/1",
                   out_valid, s, co, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // carry across slice boundaries and wrap-around
        step(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
        drain();

        // reset mid-stream: two adds in flight, third presented while reset asserts
        step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        step(1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
        in_valid = 1'b1; a = 8'h55; b = 8'h66; ci = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && s === '0 && co === 1'b0) else begin
            errors++;
            $error("FAIL mid_reset got v=%b s=%h co=%b, required 0/00/0", out_valid, s, co);
        end
        sb.delete();
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        for (int i = 0; i < ST + 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        assert (out_valid === 1'b0) else begin
            errors++;
            $error("FAIL post_reset_valid got %b, required 0", out_valid);
        end

        // backpressure: results must hold steady while refused
        lat_chk = 1'b0;
        step(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < ST; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        held_s = s; held_co = co;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'h01; b = 8'h02; ci = 1'b0; out_ready = 1'b0;
            #1;
            checks++;
            assert (out_valid === 1'b1 && in_ready === 1'b0 && s === held_s && co === held_co) else begin
                errors++;
                $error("FAIL stall got v=%b rdy=%b s=%h co=%b, required 1/0/%h/%b",
                       out_valid, in_ready, s, co, held_s, held_co);
            end
            @(negedge clk);
            cyc++;
        end
        step(1'b1, 8'h80, 8'h7F, 1'b1, 1'b1);
        step(1'b1, 8'hC8, 8'h64, 1'b0, 1'b1);
        drain();
        lat_chk = 1'b1;

        // bubbles: out_valid follows in_valid delayed by ST cycles
        bub_chk = 1'b1;
        for (int i = 0; i < 8; i++) step(i[0] ? 1'b0 : 1'b1, 8'(i * 37), 8'(i * 91), i[1], 1'b1);
        for (int i = 0; i < ST + 1; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
        bub_chk = 1'b0;
        drain();

        // operand sweep: every a against 16 spread b values, then random traffic
        for (int ai = 0; ai < 256; ai++)
            for (int bi = 0; bi < 16; bi++)
                step(1'b1, 8'(ai), 8'(bi * 17), 1'(ai ^ bi), 1'b1);
        drain();
        lat_chk = 1'b0;
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
